// File: rtl/zone_temp_control.sv
// zone_temp_control -- multi-zone greenhouse climate controller.
//
// NCH independent IDLE/COOL/HEAT hysteresis machines share one cool/heat
// threshold pair. Each zone has a dwell counter enforcing minimum on/off
// times, and the thresholds are sanity-checked every cycle.
//
// Optional feature macro: ZONE_TEMP_ALARM_EN adds per-zone sticky
// over/under-temperature alarms with a persistence filter.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous reset, active low
//   cool_th    signed cool-start threshold (W)
//   heat_th    signed heat-start threshold (W)
//   temp       signed zone temperatures, zone i at temp[i*W +: W]
//   alarm_clr  clears sticky alarms (alarm build only)
//   cool_on    per zone, registered, 1 while the zone is in COOL
//   heat_on    per zone, registered, 1 while the zone is in HEAT
//   cfg_err    registered, thresholds overlap once hysteresis is applied
//   alarm      per zone sticky alarm (0 without the alarm build)

// One zone: state machine, dwell counter, output decode, optional alarm.
module zone_temp_lane #(
  parameter int W             = 8,
  parameter int HYST          = 5,
  parameter int MIN_ON        = 4,
  parameter int MIN_OFF       = 3,
  parameter int ALARM_MARGIN  = 10,
  parameter int ALARM_PERSIST = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                force_idle,
  input  logic signed [W+1:0] cool_x,
  input  logic signed [W+1:0] heat_x,
  input  logic        [W-1:0] temp,
  input  logic                alarm_clr,
  output logic                cool_on,
  output logic                heat_on,
  output logic                alarm
);
  typedef enum logic [1:0] {IDLE = 2'd0, COOL = 2'd1, HEAT = 2'd2, BAD = 2'd3} state_t;

  localparam int DMAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int DW   = $clog2(DMAX + 1);
  localparam logic signed [W+1:0] HYST_X = (W+2)'(HYST);

  state_t              state, state_nxt;
  logic [DW-1:0]       dwell;
  logic                fresh;    // zone has not left IDLE since reset
  logic                idle_ok;
  logic signed [W+1:0] t_x;

  assign t_x     = {{2{temp[W-1]}}, temp};
  assign idle_ok = fresh || (dwell >= DW'(MIN_OFF));

  always_comb begin
    state_nxt = state;
    if (force_idle) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (idle_ok) begin
                if (t_x >= cool_x)      state_nxt = COOL;
                else if (t_x <= heat_x) state_nxt = HEAT;
              end
        // dwell is 0 on the first cycle in a state, so MIN_ON-1 gives MIN_ON cycles
        COOL: if ((t_x <= cool_x - HYST_X) && (dwell >= DW'(MIN_ON - 1))) state_nxt = IDLE;
        HEAT: if ((t_x >= heat_x + HYST_X) && (dwell >= DW'(MIN_ON - 1))) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell   <= '0;
      fresh   <= 1'b1;
      cool_on <= 1'b0;
      heat_on <= 1'b0;
    end else begin
      if (state_nxt != state)      dwell <= '0;
      else if (dwell < DW'(DMAX))  dwell <= dwell + 1'b1;
      if (state_nxt != IDLE)       fresh <= 1'b0;
      // outputs trail the state register by one edge
      cool_on <= (state == COOL);
      heat_on <= (state == HEAT);
    end
  end

`ifdef ZONE_TEMP_ALARM_EN
  localparam int PW = $clog2(ALARM_PERSIST + 1);
  localparam logic signed [W+1:0] MARGIN_X = (W+2)'(ALARM_MARGIN);

  logic [PW-1:0] pcnt;
  logic          oob, trig;

  assign oob  = (t_x >= cool_x + MARGIN_X) || (t_x <= heat_x - MARGIN_X);
  // this cycle is the ALARM_PERSIST-th consecutive out-of-band sample
  assign trig = oob && (pcnt >= PW'(ALARM_PERSIST - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt  <= '0;
      alarm <= 1'b0;
    end else begin
      if (!oob)                             pcnt <= '0;
      else if (pcnt < PW'(ALARM_PERSIST))   pcnt <= pcnt + 1'b1;
      if (trig)           alarm <= 1'b1;
      else if (alarm_clr) alarm <= 1'b0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = alarm_clr;
  assign alarm      = 1'b0;
`endif
endmodule

module zone_temp_control #(
  parameter int NCH           = 2,
  parameter int W             = 8,
  parameter int HYST          = 5,
  parameter int MIN_ON        = 4,
  parameter int MIN_OFF       = 3,
  parameter int ALARM_MARGIN  = 10,
  parameter int ALARM_PERSIST = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic signed [W-1:0]   cool_th,
  input  logic signed [W-1:0]   heat_th,
  input  logic [NCH*W-1:0]      temp,
  input  logic                  alarm_clr,
  output logic [NCH-1:0]        cool_on,
  output logic [NCH-1:0]        heat_on,
  output logic                  cfg_err,
  output logic [NCH-1:0]        alarm
);
  localparam logic signed [W+1:0] HYST_X = (W+2)'(HYST);

  // two guard bits so threshold +/- offsets never wrap
  logic signed [W+1:0] cool_x, heat_x;
  assign cool_x = {{2{cool_th[W-1]}}, cool_th};
  assign heat_x = {{2{heat_th[W-1]}}, heat_th};

  always_ff @(posedge clk) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= (heat_x + HYST_X) >= (cool_x - HYST_X);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_zone
    zone_temp_lane #(
      .W(W), .HYST(HYST), .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF),
      .ALARM_MARGIN(ALARM_MARGIN), .ALARM_PERSIST(ALARM_PERSIST)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .force_idle (cfg_err),
      .cool_x     (cool_x),
      .heat_x     (heat_x),
      .temp       (temp[i*W +: W]),
      .alarm_clr  (alarm_clr),
      .cool_on    (cool_on[i]),
      .heat_on    (heat_on[i]),
      .alarm      (alarm[i])
    );
  end
endmodule

// File: tb/tb_zone_temp_control.sv
// Testbench for zone_temp_control (NCH=2, W=8, HYST=5, MIN_ON=4, MIN_OFF=3).
// Each vector gives the inputs applied before an edge and the outputs
// expected just after it; expectations ride a queue to the sampling point.
module tb_zone_temp_control;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [7:0] cool_th = 8'sd95, heat_th = 8'sd60;
  logic [15:0]       temp = {8'd70, 8'd70};
  logic              alarm_clr = 1'b0;
  logic [1:0]        cool_on, heat_on, alarm;
  logic              cfg_err;

  always #5 clk = ~clk;

  zone_temp_control #(.NCH(2), .W(8), .HYST(5), .MIN_ON(4), .MIN_OFF(3),
                      .ALARM_MARGIN(10), .ALARM_PERSIST(3)) dut (
    .clk(clk), .rst_n(rst_n), .cool_th(cool_th), .heat_th(heat_th), .temp(temp),
    .alarm_clr(alarm_clr), .cool_on(cool_on), .heat_on(heat_on), .cfg_err(cfg_err),
    .alarm(alarm));

  typedef struct {
    int                id;
    logic              rst_n;
    logic signed [7:0] cth, hth, t0, t1;
    logic              clr;
    logic [1:0]        ec, eh, ea;
    logic              ecfg;
    logic              cm, ca;   // compare main outputs / alarm
  } vec_t;

`ifdef ZONE_TEMP_ALARM_EN
  localparam bit TBL_ALM = 1'b0;
`else
  localparam bit TBL_ALM = 1'b1;
`endif

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0, passes = 0;

  function automatic vec_t row(int id, bit r, int c, int h, int t0, int t1, bit clr,
                               bit [1:0] ec, bit [1:0] eh, bit ecfg, bit [1:0] ea,
                               bit cm, bit ca);
    vec_t v;
    v.id = id; v.rst_n = r; v.cth = 8'(c); v.hth = 8'(h); v.t0 = 8'(t0); v.t1 = 8'(t1);
    v.clr = clr; v.ec = ec; v.eh = eh; v.ecfg = ecfg; v.ea = ea; v.cm = cm; v.ca = ca;
    return v;
  endfunction

  task automatic add(bit r, int c, int h, int t0, int t1, bit [1:0] ec, bit [1:0] eh, bit ecfg);
    tbl.push_back(row(tbl.size(), r, c, h, t0, t1, 1'b0, ec, eh, ecfg, 2'b00, 1'b1, TBL_ALM));
  endtask

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL scoreboard: queue empty at sample point");
      return;
    end
    e = exp_q.pop_front();
    if (e.cm) begin
      checks++;
      if ({cool_on, heat_on, cfg_err} === {e.ec, e.eh, e.ecfg}) passes++;
      else $display("FAIL vec %0d: cool_on=%b heat_on=%b cfg_err=%b, expected %b %b %b",
                    e.id, cool_on, heat_on, cfg_err, e.ec, e.eh, e.ecfg);
    end
    if (e.ca) begin
      checks++;
      if (alarm === e.ea) passes++;
      else $display("FAIL alarm vec %0d: alarm=%b, expected %b", e.id, alarm, e.ea);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n; cool_th = v.cth; heat_th = v.hth;
    temp = {v.t1, v.t0}; alarm_clr = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    //  rst  cool heat  t0   t1   cool   heat  cfg
    add(0,  95, 60,  70,  70, 2'b00, 2'b00, 0);  // reset
    add(1,  95, 60,  70,  70, 2'b00, 2'b00, 0);
    add(1,  95, 60,  95,  70, 2'b00, 2'b00, 0);  // zone0 enters COOL at threshold
    add(1,  95, 60,  95,  70, 2'b01, 2'b00, 0);
    add(1,  95, 60,  89,  70, 2'b01, 2'b00, 0);  // below exit but MIN_ON pending
    add(1,  95, 60,  89,  70, 2'b01, 2'b00, 0);
    add(1,  95, 60,  89,  70, 2'b01, 2'b00, 0);  // leaves COOL
    add(1,  95, 60, 100,  70, 2'b00, 2'b00, 0);  // MIN_OFF blocks re-entry
    add(1,  95, 60, 100,  70, 2'b00, 2'b00, 0);
    add(1,  95, 60, 100,  70, 2'b00, 2'b00, 0);
    add(1,  95, 60, 100,  70, 2'b00, 2'b00, 0);  // re-enters COOL
    add(1,  95, 60, 100,  70, 2'b01, 2'b00, 0);
    add(1,  95, 60,  90,  70, 2'b01, 2'b00, 0);
    add(1,  95, 60,  90,  70, 2'b01, 2'b00, 0);
    add(1,  95, 60,  91,  70, 2'b01, 2'b00, 0);  // one above exit point: stay
    add(1,  95, 60,  90,  70, 2'b01, 2'b00, 0);  // exit exactly at cool_th-HYST
    add(1,  95, 60,  90,  70, 2'b00, 2'b00, 0);
    add(1,  95, 60,  90,  60, 2'b00, 2'b00, 0);  // zone1 enters HEAT at threshold
    add(1,  95, 60,  90,  64, 2'b00, 2'b10, 0);
    add(1,  95, 60,  90,  65, 2'b00, 2'b10, 0);
    add(1,  95, 60,  90,  65, 2'b00, 2'b10, 0);
    add(1,  95, 60,  90,  64, 2'b00, 2'b10, 0);  // MIN_ON met, temp not at exit
    add(1,  95, 60,  90,  65, 2'b00, 2'b10, 0);  // leaves HEAT
    add(1,  95, 60,  90,  65, 2'b00, 2'b00, 0);
    add(1,  95, 60, 100,  52, 2'b00, 2'b00, 0);
    add(1,  95, 60, 100,  52, 2'b01, 2'b00, 0);
    add(1,  95, 60, 100,  52, 2'b01, 2'b00, 0);
    add(1,  95, 60, 100,  52, 2'b01, 2'b10, 0);  // both zones active
    add(1,  70, 62, 100,  52, 2'b01, 2'b10, 1);  // bad thresholds
    add(1,  70, 62, 100,  52, 2'b01, 2'b10, 1);  // zones forced IDLE here
    add(1,  70, 62, 100,  52, 2'b00, 2'b00, 1);
    add(1,  95, 60, 100,  52, 2'b00, 2'b00, 0);  // restored
    add(1,  95, 60, 100,  52, 2'b00, 2'b00, 0);  // off-dwell after forcing
    add(1,  95, 60, 100,  52, 2'b00, 2'b00, 0);
    add(1,  95, 60, 100,  52, 2'b01, 2'b10, 0);
    add(0,  95, 60, 100,  52, 2'b00, 2'b00, 0);  // reset while active
    add(1,  95, 60, 100,  52, 2'b00, 2'b00, 0);  // no MIN_OFF wait after reset
    add(1,  95, 60, 100,  52, 2'b01, 2'b10, 0);
    foreach (tbl[i]) apply(tbl[i]);

    // Threshold raised while COOL: exit re-evaluated against the new value.
    apply(row(100, 0,  95, 60,  70, 70, 0, 2'b00, 2'b00, 0, 2'b00, 1, TBL_ALM));
    apply(row(101, 1,  95, 60, 100, 70, 0, 2'b00, 2'b00, 0, 2'b00, 1, TBL_ALM));
    for (int k = 0; k < 4; k++)
      apply(row(102 + k, 1, 95, 60, 92, 70, 0, 2'b01, 2'b00, 0, 2'b00, 1, TBL_ALM));
    apply(row(106, 1, 100, 60,  92, 70, 0, 2'b01, 2'b00, 0, 2'b00, 1, TBL_ALM));
    apply(row(107, 1, 100, 60,  92, 70, 0, 2'b00, 2'b00, 0, 2'b00, 1, TBL_ALM));

`ifdef ZONE_TEMP_ALARM_EN
    // Persistence, stickiness, clear, set-beats-clear, far negative input.
    apply(row(200, 0, 95, 60,   70, 70, 0, 0, 0, 0, 2'b00, 0, 1));
    apply(row(201, 1, 95, 60,  105, 70, 0, 0, 0, 0, 2'b00, 0, 1));
    apply(row(202, 1, 95, 60,  105, 70, 0, 0, 0, 0, 2'b00, 0, 1));
    apply(row(203, 1, 95, 60,   70, 70, 0, 0, 0, 0, 2'b00, 0, 1));
    apply(row(204, 1, 95, 60,  105, 70, 0, 0, 0, 0, 2'b00, 0, 1));
    apply(row(205, 1, 95, 60,  105, 70, 0, 0, 0, 0, 2'b00, 0, 1));
    apply(row(206, 1, 95, 60,  105, 70, 0, 0, 0, 0, 2'b01, 0, 1));
    apply(row(207, 1, 95, 60,   70, 70, 0, 0, 0, 0, 2'b01, 0, 1));
    apply(row(208, 1, 95, 60,   70, 70, 1, 0, 0, 0, 2'b00, 0, 1));
    apply(row(209, 1, 95, 60, -128, 70, 0, 0, 0, 0, 2'b00, 0, 1));
    apply(row(210, 1, 95, 60, -128, 70, 0, 0, 0, 0, 2'b00, 0, 1));
    apply(row(211, 1, 95, 60, -128, 70, 0, 0, 0, 0, 2'b01, 0, 1));
    apply(row(212, 1, 95, 60, -128, 70, 1, 0, 0, 0, 2'b01, 0, 1));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
